// File: rtl/cpu_core_p.sv
// cpu_core_p: multi-cycle FETCH/EXEC/HALT core, NREGS x DATA_W regfile, Z/C flags; op B is MUL when CPU_MUL_EN is defined.
// Latency: 2 cycles per instruction plus one per imem wait cycle; writeback pulses the cycle after EXEC.
// Backpressure: FETCH holds imem_req/imem_addr stable until imem_valid; HALT parks until reset.
module cpu_core_p #(
    parameter int DATA_W = 16,
    parameter int NREGS  = 16,
    parameter int PC_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic [15:0]       imem_rdata,
    input  logic              imem_valid,
    output logic              wb_valid,
    output logic [3:0]        wb_reg,
    output logic [DATA_W-1:0] wb_data,
    output logic              flag_z,
    output logic              flag_c,
    output logic              halted
);
    typedef enum logic [1:0] {S_FETCH, S_EXEC, S_HALT} state_t;
    localparam logic [4:0] NREGS_L = 5'(NREGS);

    state_t            state_q;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [15:0]       ir_q;
    logic [DATA_W-1:0] regs_q [16];
    logic              req_q, wb_vld_q, z_q, c_q, halt_q;
    logic [3:0]        wb_reg_q;
    logic [DATA_W-1:0] wb_dat_q;

    logic [3:0]        op, rd, rs1, rs2;
    logic [DATA_W-1:0] a, b, res_d;
    logic [DATA_W:0]   sum;
    logic              wr_d, wr_ok, flg_d, z_d, c_d;

    assign op  = ir_q[15:12];
    assign rd  = ir_q[11:8];
    assign rs1 = ir_q[7:4];
    assign rs2 = ir_q[3:0];

    // Entries at or above NREGS are never written, but reads are gated anyway.
    assign a = ({1'b0, rs1} < NREGS_L) ? regs_q[rs1] : '0;
    assign b = ({1'b0, rs2} < NREGS_L) ? regs_q[rs2] : '0;

    always_comb begin
        res_d = '0;
        sum   = '0;
        wr_d  = 1'b0;
        flg_d = 1'b0;
        c_d   = 1'b0;
        pc_d  = pc_q + PC_W'(1);
        case (op)
            4'h1: begin
                sum   = {1'b0, a} + {1'b0, b};
                res_d = sum[DATA_W-1:0];
                c_d   = sum[DATA_W];
                wr_d  = 1'b1;
                flg_d = 1'b1;
            end
            4'h2: begin
                res_d = a - b;
                c_d   = (a < b);
                wr_d  = 1'b1;
                flg_d = 1'b1;
            end
            4'h3: begin res_d = a & b; wr_d = 1'b1; flg_d = 1'b1; end
            4'h4: begin
                sum   = {1'b0, a} + {1'b0, DATA_W'(ir_q[3:0])};
                res_d = sum[DATA_W-1:0];
                c_d   = sum[DATA_W];
                wr_d  = 1'b1;
                flg_d = 1'b1;
            end
            4'h5: begin res_d = a | b; wr_d = 1'b1; flg_d = 1'b1; end
            4'h6: begin res_d = a ^ b; wr_d = 1'b1; flg_d = 1'b1; end
            4'h7: begin res_d = DATA_W'(ir_q[7:0]); wr_d = 1'b1; end
            4'h8: pc_d = PC_W'(ir_q[7:0]);
            4'h9: if (z_q)  pc_d = PC_W'(ir_q[7:0]);
            4'hA: if (!z_q) pc_d = PC_W'(ir_q[7:0]);
`ifdef CPU_MUL_EN
            4'hB: begin res_d = a * b; wr_d = 1'b1; flg_d = 1'b1; end
`endif
            default: ;
        endcase
    end

    assign z_d   = (res_d == '0);
    assign wr_ok = wr_d && (rd != 4'd0) && ({1'b0, rd} < NREGS_L);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_FETCH;
            pc_q     <= '0;
            ir_q     <= '0;
            req_q    <= 1'b0;
            wb_vld_q <= 1'b0;
            wb_reg_q <= '0;
            wb_dat_q <= '0;
            z_q      <= 1'b0;
            c_q      <= 1'b0;
            halt_q   <= 1'b0;
            for (int i = 0; i < 16; i++) regs_q[i] <= '0;
        end else begin
            wb_vld_q <= 1'b0;
            case (state_q)
                S_FETCH: begin
                    if (req_q && imem_valid) begin
                        ir_q    <= imem_rdata;
                        req_q   <= 1'b0;
                        state_q <= S_EXEC;
                    end else begin
                        req_q <= 1'b1;
                    end
                end
                S_EXEC: begin
                    pc_q <= pc_d;
                    if (flg_d) begin
                        z_q <= z_d;
                        c_q <= c_d;
                    end
                    if (wr_ok) begin
                        regs_q[rd] <= res_d;
                        wb_vld_q   <= 1'b1;
                        wb_reg_q   <= rd;
                        wb_dat_q   <= res_d;
                    end
                    if (op == 4'hF) begin
                        state_q <= S_HALT;
                        halt_q  <= 1'b1;
                    end else begin
                        state_q <= S_FETCH;
                        req_q   <= 1'b1;
                    end
                end
                default: req_q <= 1'b0;
            endcase
        end
    end

    assign imem_req  = req_q;
    assign imem_addr = pc_q;
    assign wb_valid  = wb_vld_q;
    assign wb_reg    = wb_reg_q;
    assign wb_data   = wb_dat_q;
    assign flag_z    = z_q;
    assign flag_c    = c_q;
    assign halted    = halt_q;
endmodule

// File: tb/tb_cpu_core_p.sv
// Scoreboard bench for cpu_core_p at DATA_W=16, NREGS=16, PC_W=8 with a variable-latency instruction memory.
module tb_cpu_core_p;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic [15:0] imem_rdata;
    logic        imem_valid;
    logic        wb_valid;
    logic [3:0]  wb_reg;
    logic [15:0] wb_data;
    logic        flag_z, flag_c, halted;

    always #5 clk = ~clk;

    cpu_core_p #(.DATA_W(16), .NREGS(16), .PC_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_valid(imem_valid),
        .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data),
        .flag_z(flag_z), .flag_c(flag_c), .halted(halted)
    );

    typedef struct packed {
        logic [3:0]  rg;
        logic [15:0] d;
        logic        z;
        logic        c;
    } exp_t;

    // {reg, data} of every write in the Fibonacci program, hand-traced
    localparam logic [19:0] FIB_TAB [26] = '{
        20'h1_0001, 20'h2_0001,
        20'h2_0002, 20'h3_0001, 20'h1_0002, 20'h2_0001,
        20'h2_0003, 20'h3_0002, 20'h1_0003, 20'h2_0002,
        20'h2_0005, 20'h3_0003, 20'h1_0005, 20'h2_0003,
        20'h2_0008, 20'h3_0005, 20'h1_0008, 20'h2_0005,
        20'h2_000D, 20'h3_0008, 20'h1_000D, 20'h2_0008,
        20'h2_0015, 20'h3_000D, 20'h1_0015, 20'h2_000D
    };

    exp_t        exp_q[$];
    logic [15:0] mem [256];
    int          lat = 0;
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          wb_total = 0;
    int          wb_cyc_log [512];

    function automatic void chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endfunction

    task automatic push(input logic [3:0] r, input logic [15:0] d, input logic z, input logic c);
        exp_t e;
        e.rg = r; e.d = d; e.z = z; e.c = c;
        exp_q.push_back(e);
    endtask

    task automatic put(input int a, input logic [15:0] w);
        mem[a] = w;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 16'hF000;
    endtask

    task automatic wait_halt(input string nm, input int bound);
        int n = 0;
        while (halted !== 1'b1 && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk(nm, 64'(halted), 64'(1));
    endtask

    task automatic wait_drain(input string nm, input int bound);
        int n = 0;
        while (exp_q.size() != 0 && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk(nm, 64'(exp_q.size()), 64'(0));
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: answers after lat wait cycles, drives a trap word while not valid
    initial begin
        int   cnt = 0;
        logic prev_req = 1'b0;
        logic prev_vld = 1'b0;
        logic [7:0] prev_addr = '0;
        imem_valid = 1'b0;
        imem_rdata = 16'h7F77;
        forever begin
            @(negedge clk);
            if (imem_req === 1'b1 && prev_req && !prev_vld)
                chk("addr_stable", 64'(imem_addr), 64'(prev_addr));
            prev_req  = (imem_req === 1'b1);
            prev_addr = imem_addr;
            if (imem_req === 1'b1) begin
                if (cnt >= lat) begin
                    imem_valid = 1'b1;
                    imem_rdata = mem[imem_addr];
                end else begin
                    cnt++;
                    imem_valid = 1'b0;
                    imem_rdata = 16'h7F77;
                end
            end else begin
                cnt = 0;
                imem_valid = 1'b0;
                imem_rdata = 16'h7F77;
            end
            prev_vld = imem_valid;
        end
    end

    // Writeback monitor
    always @(negedge clk) begin
        if (wb_valid === 1'b1) begin
            if (wb_total < 512) wb_cyc_log[wb_total] = cyc;
            wb_total++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL wb_unexpected reg=%0d data=%0h", wb_reg, wb_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("wb", 64'({wb_reg, wb_data, flag_z, flag_c}), 64'(e));
            end
        end
    end

    initial begin
        int base;
        int bad;
        int n;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_state", 64'({imem_req, imem_addr, wb_valid, wb_reg, wb_data, flag_z, flag_c, halted}), 64'(0));

        // Fibonacci, zero wait and 3 wait cycles
        clear_mem();
        put(0, 16'h4101); put(1, 16'h4201); put(2, 16'h1212); put(3, 16'h1310);
        put(4, 16'h1120); put(5, 16'h1230); put(6, 16'h8002);
        for (int w = 0; w < 2; w++) begin
            rst_n = 1'b0;
            repeat (2) @(negedge clk);
            lat = (w == 0) ? 0 : 3;
            for (int i = 0; i < 26; i++) push(FIB_TAB[i][19:16], FIB_TAB[i][15:0], 1'b0, 1'b0);
            base = wb_total;
            rst_n = 1'b1;
            wait_drain(w == 0 ? "fib_l0_drain" : "fib_l3_drain", 1200);
            chk(w == 0 ? "fib_l0_cycles" : "fib_l3_cycles",
                64'(wb_cyc_log[(base + 25) % 512] - wb_cyc_log[base % 512]), 64'(w == 0 ? 60 : 150));
        end

        // Wrap, flags, r0, branches, logic ops, optional MUL
        rst_n = 1'b0;
        clear_mem();
        put(8'h00, 16'h7101); put(8'h01, 16'h2101); put(8'h02, 16'h4111); put(8'h03, 16'h9010);
        put(8'h04, 16'h7F77);
        put(8'h10, 16'h4005); put(8'h11, 16'h1200); put(8'h12, 16'hA020); put(8'h13, 16'h7355);
        put(8'h14, 16'h8030); put(8'h15, 16'h7F77); put(8'h20, 16'h7F77);
        put(8'h30, 16'h2603); put(8'h31, 16'h6763); put(8'h32, 16'h3873); put(8'h33, 16'h5983);
        put(8'h34, 16'h2A99); put(8'h35, 16'h1C66); put(8'h36, 16'hA038); put(8'h37, 16'h7F77);
        put(8'h38, 16'h7107); put(8'h39, 16'h7209); put(8'h3A, 16'hB312); put(8'h3B, 16'h7E01);
        put(8'h3C, 16'h1D30); put(8'h3D, 16'hF000);
        push(4'd1, 16'h0001, 1'b0, 1'b0);
        push(4'd1, 16'hFFFF, 1'b0, 1'b1);
        push(4'd1, 16'h0000, 1'b1, 1'b1);
        push(4'd2, 16'h0000, 1'b1, 1'b0);
        push(4'd3, 16'h0055, 1'b1, 1'b0);
        push(4'd6, 16'hFFAB, 1'b0, 1'b1);
        push(4'd7, 16'hFFFE, 1'b0, 1'b0);
        push(4'd8, 16'h0054, 1'b0, 1'b0);
        push(4'd9, 16'h0055, 1'b0, 1'b0);
        push(4'd10, 16'h0000, 1'b1, 1'b0);
        push(4'd12, 16'hFF56, 1'b0, 1'b1);
        push(4'd1, 16'h0007, 1'b0, 1'b1);
        push(4'd2, 16'h0009, 1'b0, 1'b1);
`ifdef CPU_MUL_EN
        push(4'd3, 16'h003F, 1'b0, 1'b0);
        push(4'd14, 16'h0001, 1'b0, 1'b0);
        push(4'd13, 16'h003F, 1'b0, 1'b0);
`else
        push(4'd14, 16'h0001, 1'b0, 1'b1);
        push(4'd13, 16'h0055, 1'b0, 1'b0);
`endif
        repeat (2) @(negedge clk);
        lat = 1;
        rst_n = 1'b1;
        wait_halt("s3_halt", 800);
        repeat (3) @(negedge clk);
        chk("s3_drain", 64'(exp_q.size()), 64'(0));
`ifdef CPU_MUL_EN
        chk("wb_hold", 64'({wb_valid, wb_reg, wb_data}), 64'({1'b0, 4'd13, 16'h003F}));
`else
        chk("wb_hold", 64'({wb_valid, wb_reg, wb_data}), 64'({1'b0, 4'd13, 16'h0055}));
`endif
        chk("s3_flags", 64'({flag_z, flag_c}), 64'(0));

        // HALT at pc=3, 1-cycle reset pulse, reset during a writing EXEC
        rst_n = 1'b0;
        clear_mem();
        put(0, 16'h7105); put(1, 16'hC000); put(2, 16'hE000); put(3, 16'hF000);
        push(4'd1, 16'h0005, 1'b0, 1'b0);
        lat = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_halt("s5_halt", 100);
        bad = 0;
        repeat (25) begin
            @(negedge clk);
            if (halted !== 1'b1 || imem_req !== 1'b0) bad++;
        end
        chk("halt_hold", 64'(bad), 64'(0));
        chk("s5_drain", 64'(exp_q.size()), 64'(0));

        push(4'd1, 16'h0005, 1'b0, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("pulse_state", 64'({imem_addr, imem_req, halted}), 64'(0));
        n = 0;
        while (imem_req !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("refetch", 64'({imem_req, imem_addr}), 64'({1'b1, 8'h00}));
        wait_halt("pulse_halt", 100);
        repeat (2) @(negedge clk);
        chk("pulse_drain", 64'(exp_q.size()), 64'(0));

        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (!(imem_req === 1'b1 && imem_valid === 1'b1) && n < 20);
        chk("exec_seen", 64'(imem_valid), 64'(1));
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_exec_nowb", 64'({wb_valid, wb_reg, wb_data}), 64'(0));
        push(4'd1, 16'h0005, 1'b0, 1'b0);
        rst_n = 1'b1;
        wait_halt("rst_exec_halt", 100);
        repeat (2) @(negedge clk);
        chk("rst_exec_drain", 64'(exp_q.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
